// File: rtl/nv_scan_chain_ctrl.sv
// -----------------------------------------------------------------------------
// nv_scan_chain_ctrl
//
// Load/unload controller for a single scan chain of mux-D scan flops.
// Flow for each request:
//   1. Shift a parallel pattern serially into the chain head (scan_se/scan_si).
//   2. Optionally insert one functional capture cycle (scan_se low).
//   3. Shift the chain out through the tail (scan_so) into a parallel word.
//   4. Hold the result until it is consumed.
// The chain shares the controller clock. The chain cells sample scan_se and
// scan_si on the same edge on which this block advances.
//
// Parameters
//   CHAIN_LEN : number of scan cells in the chain (>= 1)
//   CNT_W     : shift-counter width
//
// Ports
//   nvdla_core_clk  : clock (also clocks the chain)
//   nvdla_core_rstn : asynchronous active-low reset
//   req_vld/req_rdy : pattern request handshake
//   req_din         : pattern; bit i lands in chain cell i (cell 0 = head)
//   req_capture     : 1 = insert one capture cycle between load and unload
//   scan_se/scan_si : scan enable / serial data to the chain head
//   scan_so         : Q of the tail cell
//   rsp_vld/rsp_rdy : result handshake
//   rsp_dout        : unloaded chain contents; bit i = cell i
//   busy            : controller is not idle
//
// Optional feature, selected by the macro NV_SCAN_CTRL_PARITY_EN:
//   rsp_parity : XOR of rsp_dout while rsp_vld is high, otherwise 0
//   par_err    : in RESP, the unloaded parity differs from the loaded pattern
//                parity and no capture was done (loopback integrity check)
//
// All outputs are decoded from flops only. No input has a combinational
// path to any output.
// -----------------------------------------------------------------------------
module nv_scan_chain_ctrl #(
    parameter int CHAIN_LEN = 32,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rstn,
    input  logic                 req_vld,
    output logic                 req_rdy,
    input  logic [CHAIN_LEN-1:0] req_din,
    input  logic                 req_capture,
    output logic                 scan_se,
    output logic                 scan_si,
    input  logic                 scan_so,
    output logic                 rsp_vld,
    input  logic                 rsp_rdy,
    output logic [CHAIN_LEN-1:0] rsp_dout,
    output logic                 busy
`ifdef NV_SCAN_CTRL_PARITY_EN
    ,
    output logic                 rsp_parity,
    output logic                 par_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CAP    = 3'd2,
        S_UNLOAD = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [CHAIN_LEN-1:0] pat_reg, pat_next;
    logic [CHAIN_LEN-1:0] dout_reg, dout_next;
    logic                 cap_reg, cap_next;
    logic                 cnt_last;

    assign cnt_last = (cnt_reg == CNT_LAST);

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            pat_reg   <= '0;
            dout_reg  <= '0;
            cap_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pat_reg   <= pat_next;
            dout_reg  <= dout_next;
            cap_reg   <= cap_next;
        end
    end

    // The pattern is shifted left so the bit destined for the tail cell
    // (pattern MSB) always sits at the top and leaves first. The unload
    // shifts left as well, so the first bit out of the tail ends at the MSB.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pat_next   = pat_reg;
        dout_next  = dout_reg;
        cap_next   = cap_reg;
        req_rdy    = 1'b0;
        scan_se    = 1'b0;
        scan_si    = 1'b0;
        rsp_vld    = 1'b0;
        busy       = 1'b1;

        case (state_reg)
            S_IDLE: begin
                req_rdy = 1'b1;
                busy    = 1'b0;
                if (req_vld) begin
                    pat_next   = req_din;
                    cap_next   = req_capture;
                    cnt_next   = '0;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                scan_se  = 1'b1;
                scan_si  = pat_reg[CHAIN_LEN-1];
                pat_next = pat_reg << 1;
                if (cnt_last) begin
                    cnt_next   = '0;
                    state_next = cap_reg ? S_CAP : S_UNLOAD;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_CAP: begin
                // Counter is already 0 from the end of LOAD.
                state_next = S_UNLOAD;
            end
            S_UNLOAD: begin
                scan_se   = 1'b1;
                dout_next = (dout_reg << 1) | CHAIN_LEN'(scan_so);
                if (cnt_last) begin
                    cnt_next   = '0;
                    state_next = S_RESP;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_RESP: begin
                rsp_vld = 1'b1;
                if (rsp_rdy) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign rsp_dout = dout_reg;

`ifdef NV_SCAN_CTRL_PARITY_EN
    // Parity of the pattern as loaded, kept for the loopback check.
    logic pat_par_reg;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            pat_par_reg <= 1'b0;
        end else if (state_reg == S_IDLE && req_vld) begin
            pat_par_reg <= ^req_din;
        end
    end

    assign rsp_parity = (state_reg == S_RESP) & (^dout_reg);
    assign par_err    = (state_reg == S_RESP) & ~cap_reg &
                        ((^dout_reg) != pat_par_reg);
`endif

endmodule
